// File: rtl/shifter_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module      : shifter_pipe
// | Description : Pipelined multi-mode barrel shifter (ROL/ROR/SLL/SRL/SRA/PASS)
// |               with valid/ready elastic stages and a passthrough tag.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
module shifter_pipe #(
  parameter int CTRL  = 5,
  parameter int WIDTH = 2**CTRL,
  parameter int LVLS  = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CTRL-1:0]  in_shift,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = (CTRL + LVLS - 1) / LVLS;

  localparam logic [2:0] MODE_ROL = 3'd0;
  localparam logic [2:0] MODE_ROR = 3'd1;
  localparam logic [2:0] MODE_SLL = 3'd2;
  localparam logic [2:0] MODE_SRL = 3'd3;
  localparam logic [2:0] MODE_SRA = 3'd4;

  // One mux level. SRA keeps the MSB intact at every level, so the operand
  // sign is always available as d[WIDTH-1] in later stages.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       mode,
    input int               amt
  );
    logic [WIDTH-1:0] r;
    case (mode)
      MODE_ROL: r = (d << amt) | (d >> (WIDTH - amt));
      MODE_ROR: r = (d >> amt) | (d << (WIDTH - amt));
      MODE_SLL: r = d << amt;
      MODE_SRL: r = d >> amt;
      MODE_SRA: r = $unsigned($signed(d) >>> amt);
      default:  r = d;
    endcase
    return r;
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * LVLS;
    localparam int HI   = ((k + 1) * LVLS < CTRL) ? (k + 1) * LVLS : CTRL;
    localparam bit LAST = (k == STAGES - 1);

    logic [WIDTH-1:0]   src_data;
    logic [CTRL-LO-1:0] src_shift;
    logic [2:0]         src_mode;
    logic [TAG_W-1:0]   src_tag;
    logic               src_valid;

    logic [WIDTH-1:0]   data_r;
    logic [TAG_W-1:0]   tag_r;
    logic               valid_r;
    logic               ld;

    if (k == 0) begin : g_src_in
      assign src_data  = in_data;
      assign src_shift = in_shift;
      assign src_mode  = in_mode;
      assign src_tag   = in_tag;
      assign src_valid = in_valid;
    end else begin : g_src_prev
      assign src_data  = g_stage[k-1].data_r;
      assign src_shift = g_stage[k-1].g_carry.shift_r;
      assign src_mode  = g_stage[k-1].g_carry.mode_r;
      assign src_tag   = g_stage[k-1].tag_r;
      assign src_valid = g_stage[k-1].valid_r;
    end

    // Bit 0 of src_shift always corresponds to level LO of this stage.
    for (genvar i = LO; i < HI; i++) begin : g_level
      logic [WIDTH-1:0] lin;
      logic [WIDTH-1:0] lout;
      if (i == LO) begin : g_first
        assign lin = src_data;
      end else begin : g_chain
        assign lin = g_level[i-1].lout;
      end
      assign lout = src_shift[i-LO] ? shift_level(lin, src_mode, 1 << i) : lin;
    end

    if (LAST) begin : g_ld_last
      assign ld = !valid_r || out_ready;
    end else begin : g_ld_mid
      assign ld = !valid_r || g_stage[k+1].ld;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_r <= 1'b0;
        data_r  <= '0;
        tag_r   <= '0;
      end else if (ld) begin
        valid_r <= src_valid;
        if (src_valid) begin
          data_r <= g_level[HI-1].lout;
          tag_r  <= src_tag;
        end
      end
    end

    // Only the not-yet-consumed shift bits and the mode travel onward.
    if (!LAST) begin : g_carry
      logic [CTRL-HI-1:0] shift_r;
      logic [2:0]         mode_r;
      always_ff @(posedge clk) begin
        if (rst) begin
          shift_r <= '0;
          mode_r  <= '0;
        end else if (ld && src_valid) begin
          shift_r <= src_shift[CTRL-LO-1:HI-LO];
          mode_r  <= src_mode;
        end
      end
    end
  end

  assign in_ready  = g_stage[0].ld;
  assign out_valid = g_stage[STAGES-1].valid_r;
  assign out_data  = g_stage[STAGES-1].data_r;
  assign out_tag   = g_stage[STAGES-1].tag_r;

endmodule
`default_nettype wire

// File: tb/tb_shifter_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module      : tb_shifter_pipe
// | Description : Self-checking bench for shifter_pipe (default, CTRL=3/LVLS=1,
// |               CTRL=6/LVLS=6) against a bit-permutation reference model.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
module tb_shifter_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic        sweep_en  = 1'b0;
  logic [2:0]  in_mode   = 3'd0;
  logic [3:0]  in_tag    = 4'd0;
  logic [63:0] stim_data = 64'd0;
  logic [5:0]  stim_shift = 6'd0;
  logic        b_valid;
  assign b_valid = in_valid & sweep_en;

  logic        a_ready, a_ovalid;
  logic [31:0] a_odata;
  logic [3:0]  a_otag;
  logic        b_ready, b_ovalid;
  logic [7:0]  b_odata;
  logic [3:0]  b_otag;
  logic        c_ready, c_ovalid;
  logic [63:0] c_odata;
  logic [3:0]  c_otag;

  shifter_pipe u_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready),
    .in_data(stim_data[31:0]), .in_shift(stim_shift[4:0]), .in_mode(in_mode),
    .in_tag(in_tag), .out_valid(a_ovalid), .out_ready(out_ready),
    .out_data(a_odata), .out_tag(a_otag)
  );

  shifter_pipe #(.CTRL(3), .LVLS(1)) u_c3 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(stim_data[7:0]), .in_shift(stim_shift[2:0]), .in_mode(in_mode),
    .in_tag(in_tag), .out_valid(b_ovalid), .out_ready(out_ready),
    .out_data(b_odata), .out_tag(b_otag)
  );

  shifter_pipe #(.CTRL(6), .LVLS(6)) u_c6 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(c_ready),
    .in_data(stim_data), .in_shift(stim_shift), .in_mode(in_mode),
    .in_tag(in_tag), .out_valid(c_ovalid), .out_ready(out_ready),
    .out_data(c_odata), .out_tag(c_otag)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    int          edg;
  } exp_t;

  exp_t        q [3][$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          tcount = 0;
  logic        use_dir = 1'b0;
  logic [63:0] dir_exp = 64'd0;
  logic        lat_chk = 1'b0;
  logic        full_rate = 1'b0;
  logic        bp = 1'b0;
  logic        saw_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Result bit j of a w-bit word, straight from the mode definitions.
  function automatic logic [63:0] model(input logic [63:0] x_in, input int n,
                                        input int mode, input int w);
    logic [63:0] mask, x, r;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    x = x_in & mask;
    r = x;
    for (int j = 0; j < w; j++) begin
      case (mode)
        0:       r[(j + n) % w] = x[j];
        1:       r[(j - n + w) % w] = x[j];
        2:       r[j] = (j >= n) ? x[j - n] : 1'b0;
        3:       r[j] = (j + n < w) ? x[j + n] : 1'b0;
        4:       r[j] = (j + n < w) ? x[j + n] : x[w - 1];
        default: r[j] = x[j];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic mon(input int id, input int w, input int s, input logic acc,
                     input logic [63:0] din, input int sh, input logic ov,
                     input logic [63:0] od, input logic [3:0] ot);
    exp_t e;
    if (ov && out_ready) begin
      if (q[id].size() == 0) begin
        chk($sformatf("dut%0d unexpected beat (queue size)", id), 64'(q[id].size()), 64'd1);
      end else begin
        e = q[id].pop_front();
        chk($sformatf("dut%0d data tag%0d", id, e.tag), od, e.data);
        chk($sformatf("dut%0d tag", id), {60'd0, ot}, {60'd0, e.tag});
        if (lat_chk) chk($sformatf("dut%0d latency", id), 64'(cyc + 1 - e.edg), 64'(s));
      end
    end
    if (acc) begin
      e.data = (use_dir && id == 0) ? dir_exp : model(din, sh, int'(in_mode), w);
      e.tag  = in_tag;
      e.edg  = cyc + 1;
      q[id].push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q[0].delete();
      q[1].delete();
      q[2].delete();
    end else begin
      if (full_rate) chk("in_ready at full rate", {63'd0, a_ready}, 64'd1);
      if (bp && in_valid && !a_ready) saw_stall = 1'b1;
      mon(0, 32, 3, in_valid && a_ready, {32'd0, stim_data[31:0]}, int'(stim_shift[4:0]),
          a_ovalid, {32'd0, a_odata}, a_otag);
      mon(1, 8, 3, b_valid && b_ready, {56'd0, stim_data[7:0]}, int'(stim_shift[2:0]),
          b_ovalid, {56'd0, b_odata}, b_otag);
      mon(2, 64, 1, b_valid && c_ready, stim_data, int'(stim_shift),
          c_ovalid, c_odata, c_otag);
    end
  end

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input int sh, input int mode, input int tag);
    logic acc;
    acc = 1'b0;
    stim_data  = d;
    stim_shift = 6'(sh);
    in_mode    = 3'(mode);
    in_tag     = 4'(tag);
    in_valid   = 1'b1;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = a_ready;
      sync();
      if (bp) begin
        tcount++;
        if (tcount >= 4) out_ready = 1'($urandom_range(0, 1));
      end
    end
    chk("input accepted", {63'd0, acc}, 64'd1);
  endtask

  task automatic dsend(input logic [31:0] d, input int sh, input int mode,
                       input int tag, input logic [31:0] exp);
    use_dir = 1'b1;
    dir_exp = {32'd0, exp};
    send({32'd0, d}, sh, mode, tag);
    use_dir = 1'b0;
  endtask

  task automatic drain;
    in_valid = 1'b0;
    for (int t = 0; t < 60 && (q[0].size() + q[1].size() + q[2].size()) != 0; t++) sync();
    chk("pipeline drained", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", {63'd0, a_ovalid}, 64'd0);
    chk("reset out_data", {32'd0, a_odata}, 64'd0);
    chk("reset out_tag", {60'd0, a_otag}, 64'd0);
    chk("reset c6 out_data", c_odata, 64'd0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", {63'd0, a_ready}, 64'd1);
    sync();

    // Directed beats, no backpressure
    lat_chk = 1'b1;
    dsend(32'h8000_0001, 1, 0, 1, 32'h0000_0003);
    dsend(32'h0000_00F1, 4, 1, 2, 32'h1000_000F);
    dsend(32'hFFFF_FFFF, 8, 2, 3, 32'hFFFF_FF00);
    dsend(32'h8000_0000, 31, 4, 4, 32'hFFFF_FFFF);
    dsend(32'h7FFF_FFFF, 31, 4, 5, 32'h0000_0000);
    dsend(32'h8000_0000, 31, 3, 6, 32'h0000_0001);
    dsend(32'hDEAD_BEEF, 13, 6, 7, 32'hDEAD_BEEF);
    dsend(32'h8000_0000, 0, 4, 8, 32'h8000_0000);
    dsend(32'h1234_5679, 31, 2, 9, 32'h8000_0000);
    dsend(32'hCAFE_F00D, 0, 0, 10, 32'hCAFE_F00D);
    drain();

    // Backpressure: 8 beats, tags 0..7
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    bp        = 1'b1;
    tcount    = 0;
    for (int i = 0; i < 8; i++)
      send({$urandom, $urandom}, int'($urandom_range(0, 31)), int'($urandom_range(0, 7)), i);
    bp        = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("in_ready stalled under backpressure", {63'd0, saw_stall}, 64'd1);

    // Full-rate random streaming on all three configurations
    lat_chk   = 1'b1;
    sweep_en  = 1'b1;
    full_rate = 1'b1;
    for (int i = 0; i < 100; i++)
      send({$urandom, $urandom}, int'($urandom_range(0, 63)), int'($urandom_range(0, 7)), i);
    full_rate = 1'b0;
    drain();

    // Every mode x every 3-bit shift
    for (int m = 0; m < 8; m++)
      for (int s = 0; s < 8; s++)
        send({$urandom, $urandom}, (int'($urandom_range(0, 7)) << 3) | s, m, m + s);
    drain();
    sweep_en = 1'b0;

    // Mid-stream reset with three beats in flight
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, i + 1, 0, 12 + i);
    rst      = 1'b1;
    in_valid = 1'b1;
    sync();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("post-reset out_valid", {63'd0, a_ovalid}, 64'd0);
    chk("post-reset out_data", {32'd0, a_odata}, 64'd0);
    out_ready = 1'b1;
    repeat (6) sync();
    lat_chk = 1'b1;
    dsend(32'h0000_0081, 3, 1, 9, 32'h2000_0010);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
